// File: rtl/l1a_fifo_writer_pkg.sv
// rtl/l1a_fifo_writer_pkg.sv - shared constants, FSM encoding and snapshot record for the L1A FIFO writer
package l1a_fifo_writer_pkg;

  localparam int L1W_P   = 24;
  localparam int NCFEB_P = 7;

  localparam logic [1:0] TAG_B4  = 2'b10;
  localparam logic [1:0] TAG_L1L = 2'b00;
  localparam logic [1:0] TAG_L1H = 2'b01;
  localparam logic [1:0] TAG_B5  = 2'b11;

  localparam logic [3:0] NIB_B4  = 4'hB;
  localparam logic [3:0] NIB_L1L = 4'h0;
  localparam logic [3:0] NIB_L1H = 4'h1;
  localparam logic [3:0] NIB_B5  = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_B4,
    ST_WR_L1L,
    ST_WR_L1H,
    ST_WR_B5
  } state_e;

  typedef struct packed {
    logic               trans;
    logic               alct;
    logic               tmb;
    logic [NCFEB_P-1:0] cfeb;
    logic [L1W_P-1:0]   num;
  } snap_t;

  function automatic logic [17:0] mk_word(input logic [1:0] tag, input logic [15:0] data);
    return {tag, data};
  endfunction

endpackage

// File: rtl/l1a_snap_fifo.sv
// rtl/l1a_snap_fifo.sv - first-word-fall-through snapshot queue with push/pop/full/empty
module l1a_snap_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a push into a full queue still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/l1a_fifo_writer.sv
// rtl/l1a_fifo_writer.sv - numbers each L1A, snapshots activity flags and writes a 4-word record to the L1A FIFO
module l1a_fifo_writer
  import l1a_fifo_writer_pkg::*;
#(
  parameter int SNAP_DEPTH = 4,
  parameter int L1W        = L1W_P,
  parameter int NCFEB      = NCFEB_P
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             L1A,
  input  logic             L1A_MATCH,
  input  logic             ALCT_ACT,
  input  logic             TMB_ACT,
  input  logic [NCFEB-1:0] CFEB_ACT,
  input  logic             EVCNT_RST,
  input  logic             FIFO_FULL,
  output logic             WR_EN,
  output logic [17:0]      WR_DATA,
  output logic             BUSY,
  output logic             OVFL,
  output logic [L1W-1:0]   L1A_CNT
);

  localparam int CW = $clog2(SNAP_DEPTH) + 1;

  state_e         state_q, state_d;
  logic [L1W-1:0] cnt_q, cnt_d;
  logic           ovfl_q, ovfl_d;
  logic           drop_pend_q, drop_pend_d;

  snap_t          push_rec, head;
  logic           q_full, q_empty, pop, drop, b5_wr;
  logic [CW-1:0]  q_count;

  always_comb begin
    cnt_d = EVCNT_RST ? '0 : cnt_q;
    if (L1A) cnt_d = cnt_d + L1W'(1);
  end

  assign push_rec = '{trans: L1A_MATCH, alct: ALCT_ACT, tmb: TMB_ACT, cfeb: CFEB_ACT, num: cnt_d};

  assign WR_EN = (state_q != ST_IDLE) && !FIFO_FULL;
  assign b5_wr = (state_q == ST_WR_B5) && WR_EN;
  assign pop   = b5_wr;
  assign drop  = L1A && q_full && !pop;

  l1a_snap_fifo #(
    .DEPTH (SNAP_DEPTH),
    .W     ($bits(snap_t))
  ) u_snap_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (L1A),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // A drop in the same cycle as a B5 write belongs to the next B5.
  assign ovfl_d      = (EVCNT_RST ? 1'b0 : ovfl_q) | drop;
  assign drop_pend_d = (b5_wr ? 1'b0 : drop_pend_q) | drop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!q_empty) state_d = ST_WR_B4;
      ST_WR_B4:  if (WR_EN) state_d = ST_WR_L1L;
      ST_WR_L1L: if (WR_EN) state_d = ST_WR_L1H;
      ST_WR_L1H: if (WR_EN) state_d = ST_WR_B5;
      ST_WR_B5:  if (WR_EN) state_d = ((q_count > CW'(1)) || L1A) ? ST_WR_B4 : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    WR_DATA = '0;
    unique case (state_q)
      ST_WR_B4:  WR_DATA = mk_word(TAG_B4, {NIB_B4, head.alct, head.tmb, head.trans, 2'b00, head.cfeb});
      ST_WR_L1L: WR_DATA = mk_word(TAG_L1L, {NIB_L1L, head.num[11:0]});
      ST_WR_L1H: WR_DATA = mk_word(TAG_L1H, {NIB_L1H, head.num[23:12]});
      ST_WR_B5:  WR_DATA = mk_word(TAG_B5, {NIB_B5, 11'b0, drop_pend_q});
      default:   WR_DATA = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ovfl_q      <= 1'b0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovfl_q      <= ovfl_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  assign BUSY    = (state_q != ST_IDLE) || !q_empty;
  assign OVFL    = ovfl_q;
  assign L1A_CNT = cnt_q;

endmodule
